// File: rtl/cw_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : cw_bus_master
//  Description : Bridges the core's single-outstanding memory request port
//                onto the 16-bit multiplexed CW bus. Generates cw_clk at
//                i_clk/2, sequences ADDR_LO / ADDR_HI / DATA phases, waits for
//                cw_ack / cw_err with a timeout and returns a one-cycle
//                response pulse to the core.
//
//  Ports
//    i_clk, i_rst              core clock, asynchronous active-high reset
//    i_req_valid/we/addr/data  request from the core (accepted on valid&ready)
//    o_req_ready               high in IDLE while no request is held
//    o_resp_valid/data/err     one-cycle response pulse to the core
//    cw_clk                    bus clock (i_clk/2, starts at 0 after reset)
//    cw_io_o / cw_io_i         bus data out / in
//    cw_dir                    1 = master drives cw_io
//    cw_req                    transaction in progress
//    cw_ack / cw_err           slave acknowledge / error
//    cw_rst                    bus reset
//
//  Revision    : 1.0 - initial release
// ============================================================================
module cw_bus_master #(
    parameter int TIMEOUT    = 255,
    parameter int RST_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [23:0] i_req_addr,
    input  logic [15:0] i_req_data,
    output logic        o_req_ready,
    output logic        o_resp_valid,
    output logic [15:0] o_resp_data,
    output logic        o_resp_err,
    output logic        cw_clk,
    output logic [15:0] cw_io_o,
    input  logic [15:0] cw_io_i,
    output logic        cw_dir,
    output logic        cw_req,
    input  logic        cw_ack,
    input  logic        cw_err,
    output logic        cw_rst
);

    typedef enum logic [2:0] {
        S_RST     = 3'd0,
        S_IDLE    = 3'd1,
        S_ADDR_LO = 3'd2,
        S_ADDR_HI = 3'd3,
        S_DATA    = 3'd4
    } state_t;

    localparam logic [7:0] c_RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [7:0] c_TO_LAST  = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_cw_clk;
    logic [7:0]  r_cnt;        // reset-hold counter in RST, timeout counter in DATA
    logic        r_pend;       // request latched, waiting for the next fall tick
    logic        r_we;
    logic [23:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [15:0] r_resp_data;

    logic        w_tick;
    logic        w_ready;
    logic        w_accept;
    logic        w_done;
    logic        w_req;
    logic        w_dir;
    logic        w_cwrst;
    logic [15:0] w_io;

    // The fall tick is the i_clk edge on which cw_clk goes 1 -> 0.
    assign w_tick   = r_cw_clk;
    assign w_accept = i_req_valid & w_ready;

    // ------------------------------------------------------------------
    // Next-state and bus output decode. Bus outputs depend only on the
    // state and the latched request, so they change only on fall ticks.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_req       = 1'b0;
        w_dir       = 1'b0;
        w_cwrst     = 1'b0;
        w_io        = 16'h0000;
        case (r_state)
            S_RST: begin
                w_cwrst = 1'b1;
                if (w_tick && (r_cnt == c_RST_LAST)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_ready = ~r_pend;
                // A request accepted on the tick edge itself leaves IDLE at once.
                if (w_tick && (r_pend || i_req_valid)) begin
                    w_state_nxt = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                w_req = 1'b1;
                w_dir = 1'b1;
                w_io  = r_addr[15:0];
                if (w_tick) begin
                    w_state_nxt = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                w_req = 1'b1;
                w_dir = 1'b1;
                w_io  = {r_we, 7'b0000000, r_addr[23:16]};
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_req = 1'b1;
                w_dir = r_we;                 // pads released for reads
                w_io  = r_we ? r_wdata : 16'h0000;
                if (w_tick && (cw_ack || cw_err || (r_cnt == c_TO_LAST))) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_RST;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register, bus clock and shared counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_RST;
            r_cw_clk <= 1'b0;
            r_cnt    <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_cw_clk <= ~r_cw_clk;
            if (w_tick) begin
                if (r_state == S_ADDR_HI) begin
                    r_cnt <= 8'h00;
                end else if (((r_state == S_RST) || (r_state == S_DATA)) && (r_cnt != 8'hFF)) begin
                    r_cnt <= r_cnt + 8'h01;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 24'h000000;
            r_wdata <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_data;
            end
            if ((r_state == S_IDLE) && (w_state_nxt == S_ADDR_LO)) begin
                r_pend <= 1'b0;
            end else if (w_accept) begin
                r_pend <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pulse; err dominates ack, a timeout has neither.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= 16'h0000;
        end else begin
            r_resp_valid <= w_done;
            r_resp_err   <= w_done & (cw_err | ~cw_ack);
            r_resp_data  <= (w_done && cw_ack && !cw_err && !r_we) ? cw_io_i : 16'h0000;
        end
    end

    assign o_req_ready  = w_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_resp_err   = r_resp_err;
    assign cw_clk       = r_cw_clk;
    assign cw_io_o      = w_io;
    assign cw_dir       = w_dir;
    assign cw_req       = w_req;
    assign cw_rst       = w_cwrst;

endmodule
`default_nettype wire

// File: tb/tb_cw_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cw_bus_master
//  Description : Self-checking bench for cw_bus_master. A transaction-level
//                timeline model predicts, for every i_clk cycle counted from
//                reset release, what each output must be; a compare process
//                checks the DUT against it on every falling i_clk edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cw_bus_master;

    localparam int TMO  = 255;
    localparam int RSTC = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        i_req_we = 1'b0;
    logic [23:0] i_req_addr = 24'h0;
    logic [15:0] i_req_data = 16'h0;
    logic        o_req_ready;
    logic        o_resp_valid;
    logic [15:0] o_resp_data;
    logic        o_resp_err;
    logic        cw_clk;
    logic [15:0] cw_io_o;
    logic [15:0] cw_io_i = 16'h0;
    logic        cw_dir;
    logic        cw_req;
    logic        cw_ack = 1'b0;
    logic        cw_err = 1'b0;
    logic        cw_rst;

    cw_bus_master #(.TIMEOUT(TMO), .RST_CYCLES(RSTC)) u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .i_req_we     (i_req_we),
        .i_req_addr   (i_req_addr),
        .i_req_data   (i_req_data),
        .o_req_ready  (o_req_ready),
        .o_resp_valid (o_resp_valid),
        .o_resp_data  (o_resp_data),
        .o_resp_err   (o_resp_err),
        .cw_clk       (cw_clk),
        .cw_io_o      (cw_io_o),
        .cw_io_i      (cw_io_i),
        .cw_dir       (cw_dir),
        .cw_req       (cw_req),
        .cw_ack       (cw_ack),
        .cw_err       (cw_err),
        .cw_rst       (cw_rst)
    );

    always #5 i_clk = ~i_clk;

    // t = number of rising i_clk edges since reset release. Fall ticks are
    // the even edges t >= 2.
    int  t = 0;
    int  n_vec = 0;
    int  n_err = 0;
    bit  run = 1'b0;

    // Plan of the current transaction (edge numbers on the t axis):
    //   p_a accept edge, p_L ADDR_LO entry, p_D DATA entry, p_E terminating tick.
    // mode: 0 ack, 1 err, 2 ack+err, 3 no answer (timeout).
    bit          p_valid = 1'b0;
    logic        p_we = 1'b0;
    logic [23:0] p_addr = 24'h0;
    logic [15:0] p_data = 16'h0;
    logic [15:0] p_rdata = 16'h0;
    int          p_mode = 0;
    int          p_a = 0, p_L = 0, p_D = 0, p_E = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
        end
    endtask

    // Slave behaviour for the edge t+1: random noise everywhere except the
    // DATA ticks, which are quiet until the planned terminating tick.
    task automatic drive_slave();
        int e = t + 1;
        cw_io_i = 16'($urandom);
        cw_ack  = ($urandom_range(0, 3) == 0);
        cw_err  = ($urandom_range(0, 3) == 0);
        if (p_valid && (e > p_D) && (e < p_E) && (e % 2 == 0)) begin
            cw_ack = 1'b0;
            cw_err = 1'b0;
        end
        if (p_valid && (e == p_E)) begin
            cw_ack  = (p_mode == 0) || (p_mode == 2);
            cw_err  = (p_mode == 1) || (p_mode == 2);
            cw_io_i = p_rdata;
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        t = t + 1;
        drive_slave();
    endtask

    // Called at posedge+1: present a request for the next edge and plan it.
    task automatic present(input logic we, input logic [23:0] addr, input logic [15:0] data,
                           input logic [15:0] rdata, input int mode, input int k);
        p_we    = we;
        p_addr  = addr;
        p_data  = data;
        p_rdata = rdata;
        p_mode  = mode;
        p_a     = (t + 1 > 2 * RSTC + 1) ? t + 1 : 2 * RSTC + 1;
        p_L     = p_a + (p_a % 2);
        p_D     = p_L + 4;
        p_E     = p_D + 2 * k;
        p_valid = 1'b1;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_data  = data;
    endtask

    task automatic drop_req();
        i_req_valid = 1'b0;
        i_req_we    = 1'($urandom);
        i_req_addr  = 24'($urandom);
        i_req_data  = 16'($urandom);
    endtask

    task automatic run_txn(input logic we, input logic [23:0] addr, input logic [15:0] data,
                           input logic [15:0] rdata, input int mode, input int k, input int dl,
                           input bit lit, input logic [15:0] l_lo, input logic [15:0] l_hi,
                           input logic [15:0] l_dat, input logic l_dir,
                           input logic [15:0] l_rd, input logic l_err);
        for (int i = 0; i < dl; i++) step();
        present(we, addr, data, rdata, mode, k);
        while (t < p_E + 1) begin
            step();
            if (t == p_a) drop_req();
            if (lit) begin
                if (t == p_L)     chk("lit_addr_lo", cw_io_o, l_lo);
                if (t == p_L + 2) chk("lit_addr_hi", cw_io_o, l_hi);
                if (t == p_D) begin
                    chk("lit_data_io", cw_io_o, l_dat);
                    chk("lit_data_dir", cw_dir, l_dir);
                end
                if (t == p_E - 1) chk("lit_resp_early", o_resp_valid, 0);
                if (t == p_E) begin
                    chk("lit_resp_valid", o_resp_valid, 1);
                    chk("lit_resp_data", o_resp_data, l_rd);
                    chk("lit_resp_err", o_resp_err, l_err);
                    chk("lit_req_drop", cw_req, 0);
                end
                if (t == p_E + 1) chk("lit_resp_once", o_resp_valid, 0);
            end
        end
    endtask

    // Called at posedge+1: release reset and watch the bus-reset sequence.
    task automatic release_and_check();
        #2;
        i_rst = 1'b0;
        t = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (t == 1) chk("lit_cwclk_hi", cw_clk, 1);
            if (t == 2) chk("lit_cwclk_lo", cw_clk, 0);
            if (t == 2 * RSTC - 1) chk("lit_cwrst_hold", cw_rst, 1);
            if (t == 2 * RSTC) begin
                chk("lit_cwrst_rel", cw_rst, 0);
                chk("lit_ready_idle", o_req_ready, 1);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process: timeline model against the DUT, every cycle.
    // ------------------------------------------------------------------
    always @(negedge i_clk) begin : cmp
        logic        e_clk, e_rst, e_rdy, e_req, e_dir, e_rv, e_re;
        logic [15:0] e_io, e_rd;
        if (run) begin
            e_clk = 1'b0; e_rst = 1'b0; e_rdy = 1'b0; e_req = 1'b0; e_dir = 1'b0;
            e_rv  = 1'b0; e_re  = 1'b0; e_io  = 16'h0; e_rd = 16'h0;
            if (i_rst) begin
                e_rst = 1'b1;
            end else begin
                e_clk = (t % 2 == 1);
                e_rst = (t < 2 * RSTC);
                e_rdy = (t >= 2 * RSTC) && !(p_valid && (t >= p_a) && (t < p_E));
                if (p_valid) begin
                    if ((t >= p_L) && (t < p_L + 2)) begin
                        e_req = 1'b1; e_dir = 1'b1; e_io = p_addr[15:0];
                    end else if ((t >= p_L + 2) && (t < p_D)) begin
                        e_req = 1'b1; e_dir = 1'b1; e_io = {p_we, 7'b0, p_addr[23:16]};
                    end else if ((t >= p_D) && (t < p_E)) begin
                        e_req = 1'b1; e_dir = p_we; e_io = p_we ? p_data : 16'h0;
                    end
                    if (t == p_E) begin
                        e_rv = 1'b1;
                        e_re = (p_mode != 0);
                        e_rd = ((p_mode == 0) && !p_we) ? p_rdata : 16'h0;
                    end
                end
            end
            chk("cw_clk", cw_clk, e_clk);
            chk("cw_rst", cw_rst, e_rst);
            chk("o_req_ready", o_req_ready, e_rdy);
            chk("cw_req", cw_req, e_req);
            chk("cw_dir", cw_dir, e_dir);
            chk("cw_io_o", cw_io_o, e_io);
            chk("o_resp_valid", o_resp_valid, e_rv);
            chk("o_resp_err", o_resp_err, e_re);
            chk("o_resp_data", o_resp_data, e_rd);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        #1;
        i_rst = 1'b1;
        run   = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        release_and_check();

        // Write 0x123456 <- 0xBEEF, ack on the first DATA tick.
        run_txn(1'b1, 24'h123456, 16'hBEEF, 16'h0000, 0, 1, 0,
                1'b1, 16'h3456, 16'h8012, 16'hBEEF, 1'b1, 16'h0000, 1'b0);
        // Read 0x000010, slave returns 0xA5A5 with ack on the third DATA tick.
        run_txn(1'b0, 24'h000010, 16'h1111, 16'hA5A5, 0, 3, 1,
                1'b1, 16'h0010, 16'h0000, 16'h0000, 1'b0, 16'hA5A5, 1'b0);
        // Read with ack and err together: err wins.
        run_txn(1'b0, 24'h00ABCD, 16'h0000, 16'h5A5A, 2, 2, 2,
                1'b1, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        // Read with no answer: timeout after TMO DATA ticks.
        run_txn(1'b0, 24'h7F0001, 16'h0000, 16'h1234, 3, TMO, 0,
                1'b1, 16'h0001, 16'h007F, 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Randomized transactions, acceptance on tick and non-tick edges.
        for (int n = 0; n < 24; n++) begin
            run_txn(1'($urandom), 24'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 3)),
                    1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        end

        // Abort a read in DATA with an asynchronous reset.
        present(1'b0, 24'h0F0F0F, 16'h0000, 16'hCAFE, 3, TMO);
        while (t < p_D + 4) begin
            step();
            if (t == p_a) drop_req();
        end
        #1;
        i_rst = 1'b1;
        #1;
        chk("async_cw_req", cw_req, 0);
        chk("async_cw_io", cw_io_o, 0);
        chk("async_cw_rst", cw_rst, 1);
        chk("async_cw_clk", cw_clk, 0);
        chk("async_ready", o_req_ready, 0);
        chk("async_resp_valid", o_resp_valid, 0);
        p_valid = 1'b0;
        repeat (3) step();
        release_and_check();

        for (int n = 0; n < 4; n++) begin
            run_txn(1'($urandom), 24'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(1, 4)),
                    int'($urandom_range(0, 3)),
                    1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        end
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
